// File: rtl/lcd_write_ctrl_if.sv
// Byte-write handshake between the game logic (master) and the LCD write controller (slave).
interface lcd_write_ctrl_if;
    logic       wr_valid;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_rs, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_rs, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_write_ctrl.sv
// HD44780 8-bit write-only sequencer: autonomous power-on init, then handshaked
// command/data writes with E setup/pulse/hold and execution delays in microsecond ticks.
module lcd_write_ctrl #(
    parameter int TICK_DIV      = 50,
    parameter int POWERON_US    = 15000,
    parameter int INIT_LONG_US  = 4100,
    parameter int INIT_SHORT_US = 100,
    parameter int CMD_US        = 40,
    parameter int CLEAR_US      = 1640,
    parameter int E_PULSE_US    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    lcd_write_ctrl_if.slave   wr,
    output logic              init_done,
    output logic              lcd_e,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic [7:0]        lcd_db
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {PWR_WAIT, INIT_LOAD, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] psc_q;
    logic [15:0]   dly_q, dly_ld, wait_q;
    logic [2:0]    k_q;
    logic          tick, expire, accept;

    assign tick     = (psc_q == PW'(TICK_DIV - 1));
    assign expire   = tick && (dly_q == '0);
    assign accept   = (state_q == IDLE) && wr.wr_valid;
    assign wr.wr_ready = (state_q == IDLE);
    assign lcd_rw   = 1'b0;

    // Init ROM: {db, wait in ticks}
    function automatic logic [23:0] rom(input logic [2:0] k);
        case (k)
            3'd0:    rom = {8'h30, 16'(INIT_LONG_US)};
            3'd1:    rom = {8'h30, 16'(INIT_SHORT_US)};
            3'd2:    rom = {8'h30, 16'(CMD_US)};
            3'd3:    rom = {8'h38, 16'(CMD_US)};
            3'd4:    rom = {8'h0C, 16'(CMD_US)};
            3'd5:    rom = {8'h01, 16'(CLEAR_US)};
            default: rom = {8'h06, 16'(CMD_US)};
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            PWR_WAIT:  if (expire) state_d = INIT_LOAD;
            INIT_LOAD: state_d = SETUP;
            SETUP:     if (expire) state_d = PULSE;
            PULSE:     if (expire) state_d = HOLD;
            HOLD:      if (expire) state_d = WAIT;
            WAIT:      if (expire) state_d = (!init_done && k_q != 3'd6) ? INIT_LOAD : IDLE;
            IDLE:      if (wr.wr_valid) state_d = SETUP;
            default:   state_d = PWR_WAIT;
        endcase
    end

    always_comb begin
        dly_ld = '0;
        case (state_d)
            PWR_WAIT: dly_ld = 16'(POWERON_US - 1);
            PULSE:    dly_ld = 16'(E_PULSE_US - 1);
            WAIT:     dly_ld = wait_q - 16'd1;
            default:  dly_ld = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PWR_WAIT;
            psc_q     <= '0;
            // Reset is itself the entry into PWR_WAIT, so the delay starts preloaded.
            dly_q     <= 16'(POWERON_US - 1);
            k_q       <= '0;
            wait_q    <= '0;
            init_done <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_db    <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                psc_q <= '0;
                dly_q <= dly_ld;
            end else begin
                psc_q <= tick ? '0 : psc_q + 1'b1;
                if (tick && dly_q != '0) dly_q <= dly_q - 16'd1;
            end
            lcd_e <= (state_d == PULSE);
            if (state_q == INIT_LOAD) begin
                {lcd_db, wait_q} <= rom(k_q);
                lcd_rs           <= 1'b0;
            end
            if (accept) begin
                lcd_rs <= wr.wr_rs;
                lcd_db <= wr.wr_data;
                // Clear and return-home need the long execution time.
                wait_q <= (!wr.wr_rs && (wr.wr_data == 8'h01 || wr.wr_data == 8'h02))
                          ? 16'(CLEAR_US) : 16'(CMD_US);
            end
            if (state_q == WAIT && expire && !init_done) begin
                k_q <= k_q + 3'd1;
                if (k_q == 3'd6) init_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Directed bench for lcd_write_ctrl: init sequence, write timing, back-to-back, reset abort.
module tb_lcd_write_ctrl;
    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_done, lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_db;

    lcd_write_ctrl_if wr_if();

    lcd_write_ctrl #(
        .TICK_DIV(TICK_DIV), .POWERON_US(10), .INIT_LONG_US(6), .INIT_SHORT_US(5),
        .CMD_US(3), .CLEAR_US(8), .E_PULSE_US(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr_if), .init_done(init_done),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse / accept recorder, sampled on the falling edge.
    int         np = 0, na = 0, rw_bad = 0;
    logic [7:0] pdb [64];
    logic       prs [64];
    int         pw [64], prise [64], acc [64];
    int         cur_w = 0, cur_rise = 0;
    logic [7:0] cur_db = '0;
    logic       cur_rs = 1'b0, e_q = 1'b0;

    always @(negedge clk) begin
        if (lcd_rw !== 1'b0) rw_bad <= rw_bad + 1;
        if (lcd_e === 1'b1) begin
            if (!e_q) begin
                cur_w <= 1; cur_db <= lcd_db; cur_rs <= lcd_rs; cur_rise <= cyc;
            end else cur_w <= cur_w + 1;
        end else if (e_q && np < 64) begin
            pdb[np] <= cur_db; prs[np] <= cur_rs; pw[np] <= cur_w; prise[np] <= cur_rise;
            np <= np + 1;
        end
        e_q <= (lcd_e === 1'b1);
        if (wr_if.wr_valid === 1'b1 && wr_if.wr_ready === 1'b1 && na < 64) begin
            acc[na] <= cyc + 1;
            na <= na + 1;
        end
    end

    int vecs = 0, nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (wr_if.wr_ready === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Call #1 after an edge with wr_ready high.
    task automatic do_write(input logic rs, input logic [7:0] d, input int exp_gap, input string tag);
        int a, r, p;
        p = np;
        wr_if.wr_valid = 1'b1; wr_if.wr_rs = rs; wr_if.wr_data = d;
        @(posedge clk); #1;
        wr_if.wr_valid = 1'b0;
        a = cyc;
        chk({tag, "_rdy_low"}, {31'd0, wr_if.wr_ready}, 32'd0);
        chk({tag, "_rs_setup"}, {31'd0, lcd_rs}, {31'd0, rs});
        chk({tag, "_db_setup"}, {24'd0, lcd_db}, {24'd0, d});
        chk({tag, "_e_low"}, {31'd0, lcd_e}, 32'd0);
        wait_ready(100, r);
        chk({tag, "_ready_gap"}, r - a, exp_gap);
        chk({tag, "_npulse"}, np - p, 1);
        chk({tag, "_e_rise"}, prise[p] - a, 4);
        chk({tag, "_e_width"}, pw[p], 4);
    endtask

    logic [7:0] init_db [7];
    logic [7:0] q [3];
    int rel, r, p0, a0;

    initial begin
        init_db = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
        q = '{8'hA1, 8'hB2, 8'hC3};
        wr_if.wr_valid = 1'b0; wr_if.wr_rs = 1'b0; wr_if.wr_data = '0;

        repeat (3) @(posedge clk); #1;
        chk("rst_e", {31'd0, lcd_e}, 0);
        chk("rst_rs", {31'd0, lcd_rs}, 0);
        chk("rst_rw", {31'd0, lcd_rw}, 0);
        chk("rst_db", {24'd0, lcd_db}, 0);
        chk("rst_ready", {31'd0, wr_if.wr_ready}, 0);
        chk("rst_init_done", {31'd0, init_done}, 0);

        rst_n = 1'b1; rel = cyc; p0 = np;
        wait_ready(400, r);
        chk("init_time", r - rel, 255);
        chk("init_done_with_ready", {31'd0, init_done}, 1);
        chk("init_npulse", np - p0, 7);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("init_db%0d", k), {24'd0, pdb[p0+k]}, {24'd0, init_db[k]});
            chk($sformatf("init_w%0d", k), pw[p0+k], 4);
            chk($sformatf("init_rs%0d", k), {31'd0, prs[p0+k]}, 0);
        end

        do_write(1'b1, 8'h41, 24, "data41");
        do_write(1'b0, 8'h01, 44, "cmd01");
        do_write(1'b1, 8'h01, 24, "data01");
        do_write(1'b0, 8'h02, 44, "cmd02");
        do_write(1'b0, 8'h03, 24, "cmd03");

        // wr_valid held across three queued bytes
        a0 = na; p0 = np;
        wr_if.wr_valid = 1'b1; wr_if.wr_rs = 1'b1; wr_if.wr_data = q[0];
        for (int j = 0; j < 3; j++) begin
            for (int t = 0; t < 100 && na <= a0 + j; t++) begin
                @(posedge clk); #1;
            end
            if (j < 2) wr_if.wr_data = q[j+1];
            else wr_if.wr_valid = 1'b0;
        end
        wait_ready(100, r);
        chk("b2b_naccept", na - a0, 3);
        chk("b2b_npulse", np - p0, 3);
        for (int j = 0; j < 3; j++)
            chk($sformatf("b2b_db%0d", j), {24'd0, pdb[p0+j]}, {24'd0, q[j]});
        chk("b2b_gap1", acc[a0+1] - acc[a0], 25);
        chk("b2b_gap2", acc[a0+2] - acc[a0+1], 25);

        // Reset while E is high
        wr_if.wr_valid = 1'b1; wr_if.wr_rs = 1'b1; wr_if.wr_data = 8'h55;
        @(posedge clk); #1;
        wr_if.wr_valid = 1'b0;
        for (int t = 0; t < 20 && lcd_e !== 1'b1; t++) begin
            @(posedge clk); #1;
        end
        chk("abort_e_high", {31'd0, lcd_e}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_e", {31'd0, lcd_e}, 0);
        chk("abort_rs", {31'd0, lcd_rs}, 0);
        chk("abort_db", {24'd0, lcd_db}, 0);
        chk("abort_ready", {31'd0, wr_if.wr_ready}, 0);
        chk("abort_init_done", {31'd0, init_done}, 0);
        repeat (2) @(posedge clk); #1;

        // Re-init with wr_valid asserted throughout
        wr_if.wr_valid = 1'b1; wr_if.wr_rs = 1'b1; wr_if.wr_data = 8'h77;
        rst_n = 1'b1; rel = cyc; p0 = np; a0 = na;
        wait_ready(400, r);
        wr_if.wr_valid = 1'b0;
        chk("reinit_time", r - rel, 255);
        chk("reinit_no_accept", na - a0, 0);
        chk("reinit_npulse", np - p0, 7);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("reinit_db%0d", k), {24'd0, pdb[p0+k]}, {24'd0, init_db[k]});
            chk($sformatf("reinit_rs%0d", k), {31'd0, prs[p0+k]}, 0);
        end

        repeat (3) @(posedge clk); #1;
        chk("rw_never_high", rw_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, nerr);
        $finish;
    end
endmodule
